xrun_ctrl: RTL and testbench
============================

XRUN_CTRL -- requirements
Module: xrun_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of engine control data ports.
REQ-002 Parameter ADDR_W, default `nMEM_W+`MEM_ADDR_W+1, width of engine address bus; the MSB selects the engine control/status register.
REQ-003 Parameter SETTLE, default 2, idle cycles between a run write and the first status poll (range 1..15).
REQ-004 Parameter TMO_W, default 16, width of the poll timeout counter.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  in  1  host requests a run batch.
REQ-008 cmd_ready  out  1  block can accept a command (high only in IDLE).
REQ-009 cmd_nruns  in  16  number of back-to-back engine runs; 0 is treated as 1.
REQ-010 eng_valid  out  1  engine access strobe.
REQ-011 eng_we  out  1  engine write enable.
REQ-012 eng_addr  out  ADDR_W  engine address; always {1'b1, zeros} when eng_valid is high.
REQ-013 eng_rdata  out  DATA_W  data written to engine; {zeros, 1'b1} during a run write, 0 otherwise.
REQ-014 eng_wdata  in  DATA_W  engine read data; bit 0 is the engine done flag, combinationally valid in the same cycle as eng_valid.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 runs_left  out  16  runs remaining in the current batch, including the one in progress.
REQ-017 irq  out  1  one-cycle pulse on batch completion or timeout.
REQ-018 err  out  1  sticky timeout flag; cleared by accepting the next command.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN, SETTLE, POLL and FIN.
REQ-020 IDLE: cmd_ready=1; on cmd_valid the block SHALL load runs_left=max(cmd_nruns,1), clear err and go to RUN next cycle.
REQ-021 RUN: exactly one cycle with eng_valid=1, eng_we=1 and eng_rdata=1; the block SHALL then load the settle counter with SETTLE-1 and go to SETTLE.
REQ-022 SETTLE: eng_valid=0; the counter SHALL decrement each cycle, and at 0 the block SHALL clear the timeout counter and go to POLL.
REQ-023 POLL: each cycle eng_valid=1 and eng_we=0; the block SHALL sample eng_wdata[0] in the same cycle.
REQ-024 POLL with done=1 and runs_left>1: the block SHALL decrement runs_left and go to RUN; there is no idle cycle between the last poll and the next run write.
REQ-025 POLL with done=1 and runs_left==1: the block SHALL set runs_left=0 and go to FIN.
REQ-026 POLL with done=0: the timeout counter SHALL increment, and on reaching all-ones the block SHALL set err=1 and go to FIN, leaving runs_left unchanged.
REQ-027 FIN: irq=1 for exactly this cycle, then the block SHALL go to IDLE; in FIN eng_valid=0 and cmd_ready=0.
REQ-028 cmd_valid outside IDLE SHALL be ignored and have no effect on state or counters.
REQ-029 eng_we SHALL never be high while eng_valid is low.
REQ-030 No more than one run write SHALL be issued per done observation, so no run is ever re-issued while the engine is busy.
REQ-031 Width rule: the timeout counter is TMO_W bits and saturating, so the timeout fires after 2^TMO_W-1 polls with done=0; runs_left never underflows.

Reset
REQ-032 While rst is low the block SHALL be in IDLE with cmd_ready=1, busy=0, eng_valid=0, eng_we=0, eng_addr=0, eng_rdata=0, runs_left=0, irq=0, err=0, and all internal counters at 0.
REQ-033 Reset asserted mid-batch SHALL abort immediately without issuing irq; after release the block SHALL accept a new command in the first cycle.

Verification
REQ-034 cmd_nruns=1, engine done=0 for 5 poll cycles and then 1 -> one write cycle (addr MSB=1, rdata=1), 2 settle cycles, 6 reads, irq for 1 cycle, runs_left=0, err=0.
REQ-035 cmd_nruns=3, done returned on the first poll -> three run writes separated by exactly SETTLE+1 cycles, runs_left 3->2->1->0, a single irq.
REQ-036 cmd_nruns=0 -> behaves identically to cmd_nruns=1.
REQ-037 TMO_W=4 with done held at 0 -> 15 polls, then err=1, irq pulse, runs_left unchanged; the next cmd_valid clears err.
REQ-038 rst pulsed low during POLL of a 4-run batch -> all outputs at reset values, no irq, and a fresh command accepted and run to completion.
REQ-039 cmd_valid held high during a batch -> no extra batch is started until IDLE; the command is accepted on the first IDLE cycle after FIN.

Source files
------------

// File: rtl/xrun_ctrl.sv
// Sequences batches of engine runs: write the run bit, wait SETTLE cycles, poll done, repeat.
// Outputs are registered; done is sampled in the same cycle as each poll strobe.
`ifndef nMEM_W
`define nMEM_W 2
`endif
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif

module xrun_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = `nMEM_W + `MEM_ADDR_W + 1,
  parameter int SETTLE = 2,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_nruns,
  output logic              eng_valid,
  output logic              eng_we,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_rdata,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              busy,
  output logic [15:0]       runs_left,
  output logic              irq,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_POLL,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] CSR_ADDR  = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] RUN_WORD  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = '1;

  state_t             r_state;
  logic [3:0]         r_settle;
  logic [TMO_W-1:0]   r_tmo;
  logic [15:0]        r_runs;
  logic               r_err;
  logic               r_irq;
  logic               r_busy;
  logic               r_cmd_ready;
  logic               r_eng_valid;
  logic               r_eng_we;
  logic [ADDR_W-1:0]  r_eng_addr;
  logic [DATA_W-1:0]  r_eng_rdata;

  logic               w_done;
  logic [15:0]        w_cmd_runs;
  logic               w_unused_wdata;

  assign w_done         = eng_wdata[0];
  assign w_unused_wdata = ^eng_wdata[DATA_W-1:1];
  assign w_cmd_runs     = (cmd_nruns == 16'd0) ? 16'd1 : cmd_nruns;

  // Strobe outputs default low each cycle and are set only on the edge entering RUN or POLL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_settle    <= '0;
      r_tmo       <= '0;
      r_runs      <= '0;
      r_err       <= 1'b0;
      r_irq       <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_eng_valid <= 1'b0;
      r_eng_we    <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_rdata <= '0;
    end else begin
      r_eng_valid <= 1'b0;
      r_eng_we    <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_rdata <= '0;
      r_irq       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_runs      <= w_cmd_runs;
            r_err       <= 1'b0;
            r_state     <= S_RUN;
            r_eng_valid <= 1'b1;
            r_eng_we    <= 1'b1;
            r_eng_addr  <= CSR_ADDR;
            r_eng_rdata <= RUN_WORD;
          end else begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_RUN: begin
          r_settle <= SETTLE_LD;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == 4'd0) begin
            r_tmo       <= '0;
            r_state     <= S_POLL;
            r_eng_valid <= 1'b1;
            r_eng_addr  <= CSR_ADDR;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_POLL: begin
          if (w_done) begin
            if (r_runs > 16'd1) begin
              r_runs      <= r_runs - 16'd1;
              r_state     <= S_RUN;
              r_eng_valid <= 1'b1;
              r_eng_we    <= 1'b1;
              r_eng_addr  <= CSR_ADDR;
              r_eng_rdata <= RUN_WORD;
            end else begin
              r_runs  <= 16'd0;
              r_state <= S_FIN;
              r_irq   <= 1'b1;
            end
          end else begin
            if (r_tmo != TMO_MAX) r_tmo <= r_tmo + TMO_ONE;
            // This poll brings the counter to all-ones: give up on the engine.
            if (r_tmo == TMO_MAX - TMO_ONE) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
              r_irq   <= 1'b1;
            end else begin
              r_eng_valid <= 1'b1;
              r_eng_addr  <= CSR_ADDR;
            end
          end
        end
        S_FIN: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign eng_valid = r_eng_valid;
  assign eng_we    = r_eng_we;
  assign eng_addr  = r_eng_addr;
  assign eng_rdata = r_eng_rdata;
  assign busy      = r_busy;
  assign runs_left = r_runs;
  assign irq       = r_irq;
  assign err       = r_err;

endmodule

// File: tb/tb_xrun_ctrl.sv
// Bench for xrun_ctrl: engine model answers polls, scoreboard holds expected run writes and irqs.
module tb_xrun_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int SETTLE = 2;
  localparam int TMO_W  = 4;
  localparam logic [ADDR_W-1:0] EXP_ADDR = {1'b1, {(ADDR_W-1){1'b0}}};

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_nruns;
  logic              eng_valid;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_rdata;
  logic [DATA_W-1:0] eng_wdata;
  logic              busy;
  logic [15:0]       runs_left;
  logic              irq;
  logic              err;

  xrun_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SETTLE(SETTLE),
    .TMO_W (TMO_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_nruns(cmd_nruns),
    .eng_valid(eng_valid),
    .eng_we   (eng_we),
    .eng_addr (eng_addr),
    .eng_rdata(eng_rdata),
    .eng_wdata(eng_wdata),
    .busy     (busy),
    .runs_left(runs_left),
    .irq      (irq),
    .err      (err)
  );

  typedef struct {
    bit          is_irq;
    logic [15:0] runs;
    logic        err;
    int          polls;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  done_after = 0;
  int  eng_polls = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  int  mon_polls = 0;
  bit  have_last = 0;
  bit  prev_irq = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: reports done once it has seen done_after polls since the last run write.
  always @(negedge clk) begin
    if (eng_valid && !eng_we) begin
      eng_wdata = (eng_polls >= done_after) ? 32'd1 : 32'd0;
      eng_polls++;
    end else begin
      eng_wdata = '0;
      if (eng_valid && eng_we) eng_polls = 0;
    end
  end

  // Monitor: bus-protocol checks every cycle, scoreboard pops on run writes and irqs.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      have_last = 0;
      prev_irq  = 0;
      mon_polls = 0;
    end else begin
      checks++;
      if (eng_we && !eng_valid) begin
        errors++;
        $display("FAIL we_without_valid: eng_we=%b eng_valid=%b, required we low", eng_we, eng_valid);
      end
      if (eng_valid) begin
        checks++;
        if (eng_addr !== EXP_ADDR) begin
          errors++;
          $display("FAIL eng_addr: got %h, required %h", eng_addr, EXP_ADDR);
        end
      end
      if (eng_valid && !eng_we) begin
        mon_polls++;
        checks++;
        if (eng_rdata !== '0) begin
          errors++;
          $display("FAIL poll_rdata: got %h, required 0", eng_rdata);
        end
      end
      if ((eng_valid && eng_we) || irq) begin
        checks++;
        if (irq && prev_irq) begin
          errors++;
          $display("FAIL irq_width: irq high two cycles in a row, required one-cycle pulse");
        end
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: irq=%b write=%b runs_left=%0d, required no event", irq, eng_we, runs_left);
        end else begin
          e = sb.pop_front();
          checks++;
          if (e.is_irq !== irq || runs_left !== e.runs) begin
            errors++;
            $display("FAIL event: got irq=%b runs_left=%0d, required irq=%b runs_left=%0d", irq, runs_left, e.is_irq, e.runs);
          end
          if (irq) begin
            checks++;
            if (err !== e.err) begin
              errors++;
              $display("FAIL irq_err: got %b, required %b", err, e.err);
            end
          end else begin
            checks++;
            if (eng_rdata !== 32'd1) begin
              errors++;
              $display("FAIL run_rdata: got %h, required 1", eng_rdata);
            end
          end
          if (have_last) begin
            checks++;
            if (mon_polls !== e.polls) begin
              errors++;
              $display("FAIL poll_count: got %0d, required %0d", mon_polls, e.polls);
            end
            checks++;
            if ((cyc - last_cyc) !== SETTLE + 1 + e.polls) begin
              errors++;
              $display("FAIL event_gap: got %0d cycles, required %0d", cyc - last_cyc, SETTLE + 1 + e.polls);
            end
          end
        end
        if (irq) begin
          have_last = 0;
        end else begin
          have_last = 1;
          last_cyc  = cyc;
          mon_polls = 0;
        end
      end
      prev_irq = irq;
      cyc++;
    end
  end

  task automatic push_ev(input bit is_irq, input logic [15:0] runs, input logic e_err, input int polls);
    ev_t e;
    e.is_irq = is_irq;
    e.runs   = runs;
    e.err    = e_err;
    e.polls  = polls;
    sb.push_back(e);
  endtask

  task automatic drive_cmd(input logic [15:0] n);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, k);
    end
    cmd_valid = 1'b1;
    cmd_nruns = n;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (eng_valid !== 1'b0 || eng_we !== 1'b0) begin errors++; $display("FAIL rst_eng_strobes: got valid=%b we=%b, required 0 0", eng_valid, eng_we); end
    checks++; if (eng_addr !== '0 || eng_rdata !== '0) begin errors++; $display("FAIL rst_eng_bus: got addr=%h rdata=%h, required 0 0", eng_addr, eng_rdata); end
    checks++; if (runs_left !== 16'd0) begin errors++; $display("FAIL rst_runs_left: got %0d, required 0", runs_left); end
    checks++; if (irq !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_irq_err: got irq=%b err=%b, required 0 0", irq, err); end
  endtask

  task automatic test_single();
    done_after = 5;
    push_ev(0, 16'd1, 1'b0, 0);
    push_ev(1, 16'd0, 1'b0, 6);
    drive_cmd(16'd1);
    wait_drain("single");
    checks++;
    if (runs_left !== 16'd0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got runs_left=%0d err=%b busy=%b, required 0 0 0", runs_left, err, busy);
    end
  endtask

  task automatic test_back_to_back();
    done_after = 0;
    push_ev(0, 16'd3, 1'b0, 0);
    push_ev(0, 16'd2, 1'b0, 1);
    push_ev(0, 16'd1, 1'b0, 1);
    push_ev(1, 16'd0, 1'b0, 1);
    drive_cmd(16'd3);
    wait_drain("back_to_back");
  endtask

  task automatic test_zero_runs();
    done_after = 5;
    push_ev(0, 16'd1, 1'b0, 0);
    push_ev(1, 16'd0, 1'b0, 6);
    drive_cmd(16'd0);
    wait_drain("zero_runs");
  endtask

  task automatic test_timeout();
    done_after = 1000;
    push_ev(0, 16'd2, 1'b0, 0);
    push_ev(1, 16'd2, 1'b1, 15);
    drive_cmd(16'd2);
    wait_drain("timeout");
    checks++;
    if (err !== 1'b1 || runs_left !== 16'd2) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b runs_left=%0d, required 1 2", err, runs_left);
    end
    done_after = 0;
    push_ev(0, 16'd1, 1'b0, 0);
    push_ev(1, 16'd0, 1'b0, 1);
    drive_cmd(16'd1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b after accept, required 0", err);
    end
    wait_drain("timeout_next");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    done_after = 3;
    push_ev(0, 16'd4, 1'b0, 0);
    drive_cmd(16'd4);
    @(negedge clk);
    while (!(eng_valid && !eng_we) && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(eng_valid && !eng_we)) begin
      errors++;
      $display("FAIL reach_poll: no poll seen after %0d cycles, required poll", k);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || eng_valid !== 1'b0 || eng_we !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got ready=%b busy=%b valid=%b we=%b, required 1 0 0 0", cmd_ready, busy, eng_valid, eng_we);
    end
    checks++;
    if (runs_left !== 16'd0 || irq !== 1'b0 || err !== 1'b0 || eng_addr !== '0) begin
      errors++;
      $display("FAIL midrst_state: got runs_left=%0d irq=%b err=%b addr=%h, required 0 0 0 0", runs_left, irq, err, eng_addr);
    end
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    done_after = 0;
    push_ev(0, 16'd2, 1'b0, 0);
    push_ev(0, 16'd1, 1'b0, 1);
    push_ev(1, 16'd0, 1'b0, 1);
    cmd_valid = 1'b1;
    cmd_nruns = 16'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || runs_left !== 16'd2) begin
      errors++;
      $display("FAIL midrst_accept: got busy=%b runs_left=%0d, required 1 2", busy, runs_left);
    end
    wait_drain("reset_mid");
  endtask

  task automatic test_hold_valid();
    int k = 0;
    done_after = 0;
    push_ev(0, 16'd2, 1'b0, 0);
    push_ev(0, 16'd1, 1'b0, 1);
    push_ev(1, 16'd0, 1'b0, 1);
    push_ev(0, 16'd2, 1'b0, 0);
    push_ev(0, 16'd1, 1'b0, 1);
    push_ev(1, 16'd0, 1'b0, 1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_nruns = 16'd2;
    @(negedge clk);
    while (!irq && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (irq !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_fin: got irq=%b cmd_ready=%b, required 1 0", irq, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (eng_we !== 1'b1 || runs_left !== 16'd2) begin
      errors++;
      $display("FAIL hold_reaccept: got we=%b runs_left=%0d, required 1 2", eng_we, runs_left);
    end
    cmd_valid = 1'b0;
    wait_drain("hold_valid");
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_nruns = 16'd0;
    eng_wdata = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_single();
    test_back_to_back();
    test_zero_runs();
    test_timeout();
    test_reset_mid();
    test_hold_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
